// File: rtl/gauss5x5_frame_sched.sv
// Frame scheduler for the 5x5 Gaussian convolver: tracks raster input into a 5-row
// circular line buffer and issues one window command per output pixel with a border mask.
// Optional stall counter enabled by defining GAUSS_SCHED_STALL_CNT_EN.
module gauss5x5_frame_sched #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 480,
  parameter int CW    = 9,
  parameter int RW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          lb_wr_en,
  output logic [2:0]    lb_wr_slot,
  output logic [CW-1:0] lb_wr_col,
  output logic          conv_valid,
  input  logic          conv_ready,
  output logic [RW-1:0] conv_row,
  output logic [CW-1:0] conv_col,
  output logic [2:0]    conv_slot,
  output logic [24:0]   border_mask,
  output logic          busy,
  output logic          frame_done,
  output logic [15:0]   stall_cnt
);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, DONE} state_t;

  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [CW:0]   COL_LAST_X = (CW+1)'(IMG_W - 1);

  state_t state, state_nxt;

  logic [RW-1:0] in_row, out_row, out_row_nxt;
  logic [CW-1:0] in_col, out_col, out_col_nxt;
  logic [2:0]    in_slot, out_slot;
  logic          start_acc, in_acc, win_acc, in_last, win_last, eligible;
  logic [RW:0]   row_lim, r2;
  logic [CW:0]   c2, cmin;

  // Taps falling outside the image are flagged so the convolver substitutes zero.
  function automatic logic [24:0] mask_of(input logic [RW-1:0] r, input logic [CW-1:0] c);
    logic [24:0] m;
    int rr, cc;
    m = '0;
    for (int p = 0; p < 5; p++) begin
      for (int q = 0; q < 5; q++) begin
        rr = int'(r) + p - 2;
        cc = int'(c) + q - 2;
        m[p*5+q] = (rr < 0) || (rr > IMG_H - 1) || (cc < 0) || (cc > IMG_W - 1);
      end
    end
    return m;
  endfunction

  // Handshakes and window eligibility, all derived from registered counters.
  always_comb begin
    start_acc = (state == IDLE) && start;
    row_lim   = {1'b0, out_row} + (RW+1)'(3);
    // Input may run at most two rows ahead of the centre row so row out_row-2 survives.
    s_ready   = (state == ACTIVE) && ({1'b0, in_row} < row_lim);
    in_acc    = s_valid && s_ready;
    in_last   = (in_row == ROW_LAST) && (in_col == COL_LAST);
    r2        = {1'b0, out_row} + (RW+1)'(2);
    c2        = {1'b0, out_col} + (CW+1)'(2);
    cmin      = (c2 > COL_LAST_X) ? COL_LAST_X : c2;
    eligible  = (state == FLUSH) || ({1'b0, in_row} > r2) ||
                (({1'b0, in_row} == r2) && ({1'b0, in_col} > cmin));
    conv_valid = ((state == ACTIVE) || (state == FLUSH)) && eligible;
    win_acc   = conv_valid && conv_ready;
    win_last  = (out_row == ROW_LAST) && (out_col == COL_LAST);
    if (out_col == COL_LAST) begin
      out_col_nxt = '0;
      out_row_nxt = out_row + RW'(1);
    end else begin
      out_col_nxt = out_col + CW'(1);
      out_row_nxt = out_row;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (in_acc && in_last) state_nxt = (win_acc && win_last) ? DONE : FLUSH;
      end
      FLUSH: begin
        if (win_acc && win_last) state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Input/output raster counters, slots and the registered border mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_row      <= '0;
      in_col      <= '0;
      in_slot     <= '0;
      out_row     <= '0;
      out_col     <= '0;
      out_slot    <= '0;
      border_mask <= '0;
    end else if (start_acc) begin
      in_row      <= '0;
      in_col      <= '0;
      in_slot     <= '0;
      out_row     <= '0;
      out_col     <= '0;
      out_slot    <= '0;
      border_mask <= mask_of('0, '0);
    end else begin
      // The final pixel/window hold their counters; the state change ends the frame.
      if (in_acc && !in_last) begin
        if (in_col == COL_LAST) begin
          in_col  <= '0;
          in_row  <= in_row + RW'(1);
          in_slot <= (in_slot == 3'd4) ? 3'd0 : in_slot + 3'd1;
        end else begin
          in_col <= in_col + CW'(1);
        end
      end
      if (win_acc && !win_last) begin
        out_row     <= out_row_nxt;
        out_col     <= out_col_nxt;
        border_mask <= mask_of(out_row_nxt, out_col_nxt);
        if (out_col == COL_LAST) out_slot <= (out_slot == 3'd4) ? 3'd0 : out_slot + 3'd1;
      end
    end
  end

  assign lb_wr_en   = in_acc;
  assign lb_wr_slot = in_slot;
  assign lb_wr_col  = in_col;
  assign conv_row   = out_row;
  assign conv_col   = out_col;
  assign conv_slot  = out_slot;

`ifdef GAUSS_SCHED_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of cycles where a ready window is held off by the convolver.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                   stall_q <= '0;
    else if (start_acc)                                        stall_q <= '0;
    else if (conv_valid && !conv_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
